// File: rtl/chan_stim_hist_if.sv
// Channel and histogram-readout bus of the chan_stim_hist engine.
//   level_out/level_valid : program level sent to the channel model
//   volt_in/volt_valid    : voltage returned by the channel
//   rd_en/rd_addr         : histogram read request, rd_addr = {level, bin}
//   rd_data/rd_valid      : bin count, one cycle after rd_en
// master = the engine, slave = the channel model / readout host.
interface chan_stim_hist_if #(
  parameter int LEVEL_BITS = 2,
  parameter int VOLT_W     = 16,
  parameter int BIN_BITS   = 6,
  parameter int HIST_W     = 20
);
  logic [LEVEL_BITS-1:0]          level_out;
  logic                           level_valid;
  logic [VOLT_W-1:0]              volt_in;
  logic                           volt_valid;
  logic                           rd_en;
  logic [LEVEL_BITS+BIN_BITS-1:0] rd_addr;
  logic [HIST_W-1:0]              rd_data;
  logic                           rd_valid;

  modport master (
    output level_out, level_valid, rd_data, rd_valid,
    input  volt_in, volt_valid, rd_en, rd_addr
  );

  modport slave (
    input  level_out, level_valid, rd_data, rd_valid,
    output volt_in, volt_valid, rd_en, rd_addr
  );
endinterface

// File: rtl/chan_stim_hist.sv
// Stimulus-and-capture engine for the NVM flash channel model.
// Drives LFSR program levels into the channel, re-aligns each level with the
// returned voltage CHAN_LAT cycles later, drops the warm-up window and bins
// accepted voltages into an on-chip per-level histogram read out in DONE.
// Ports:
//   clk, reset (async, active low), start (run / clear request)
//   bus        : chan_stim_hist_if.master (channel + histogram readout)
//   busy, done : run status
//   ovf_cnt    : samples clamped into the top bin
//   sample_cnt : accepted samples
//   min_volt, max_volt : raw voltage extremes over accepted samples
// Optional feature macro: CHAN_MINMAX_EN (min/max tracking; tied to 0 otherwise).
//
// state  | meaning
// CLEAR  | zero every histogram word, one per cycle
// IDLE   | wait for start
// WARMUP | drive levels, samples discarded
// RUN    | drive levels, samples tagged for capture
// DRAIN  | let channel latency and the RMW pipe empty
// DONE   | histogram readable, start returns to CLEAR
module chan_stim_hist #(
  parameter int          LEVEL_BITS    = 2,
  parameter int          VOLT_W        = 16,
  parameter int          BIN_BITS      = 6,
  parameter int          BIN_SHIFT     = 10,
  parameter int          HIST_W        = 20,
  parameter int          CNT_W         = 20,
  parameter int          WARMUP_CYCLES = 81,
  parameter int          TOTAL_CYCLES  = 327680,
  parameter int          CHAN_LAT      = 3,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1_2468
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  chan_stim_hist_if.master      bus,
  output logic                  busy,
  output logic                  done,
  output logic [HIST_W-1:0]     ovf_cnt,
  output logic [CNT_W-1:0]      sample_cnt,
  output logic [VOLT_W-1:0]     min_volt,
  output logic [VOLT_W-1:0]     max_volt
);
  localparam int ADDR_W  = LEVEL_BITS + BIN_BITS;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int DRAIN_W = $clog2(CHAN_LAT + 2);
  localparam logic [31:0]        LFSR_MASK  = 32'h8020_0003;
  localparam logic [CNT_W-1:0]   WARM_LAST  = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TOTAL_LAST = CNT_W'(TOTAL_CYCLES - 1);
  localparam logic [VOLT_W-1:0]  BIN_MAX    = VOLT_W'((1 << BIN_BITS) - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WARMUP, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                            state_q, state_d;
  logic [31:0]                       lfsr_q, lfsr_d;
  logic [CNT_W-1:0]                  run_cnt_q, run_cnt_d;
  logic [DRAIN_W-1:0]                drain_q, drain_d;
  logic [ADDR_W-1:0]                 clr_addr_q, clr_addr_d;
  logic                              busy_q, busy_d;
  logic [CHAN_LAT-1:0][LEVEL_BITS:0] dly_q, dly_d;
  logic                              p_valid_q, p_valid_d;
  logic [ADDR_W-1:0]                 p_addr_q, p_addr_d;
  logic                              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0]                 wb_addr_q, wb_addr_d;
  logic [HIST_W-1:0]                 wb_data_q, wb_data_d;
  logic [HIST_W-1:0]                 rdata_q, rdata_d;
  logic                              rd_valid_q, rd_valid_d;
  logic [HIST_W-1:0]                 ovf_q, ovf_d;
  logic [CNT_W-1:0]                  samp_q, samp_d;

  logic [HIST_W-1:0] mem [DEPTH];

  logic              level_valid, clr_en, acc, ovf, we, run_start;
  logic [VOLT_W-1:0] raw;
  logic [BIN_BITS-1:0] bin;
  logic [ADDR_W-1:0] acc_addr, raddr, waddr;
  logic [HIST_W-1:0] base, inc, wdata;

  assign level_valid = (state_q == S_WARMUP) || (state_q == S_RUN);
  // The first cycle after reset release is spent with busy low; the clear
  // sweep starts once busy is up so busy spans exactly the sweep.
  assign clr_en      = (state_q == S_CLEAR) && busy_q;
  assign run_start   = (state_q == S_IDLE) && start;

  assign acc      = bus.volt_valid && dly_q[CHAN_LAT-1][LEVEL_BITS];
  assign raw      = bus.volt_in >> BIN_SHIFT;
  assign ovf      = raw > BIN_MAX;
  assign bin      = ovf ? {BIN_BITS{1'b1}} : raw[BIN_BITS-1:0];
  assign acc_addr = {dly_q[CHAN_LAT-1][LEVEL_BITS-1:0], bin};

  // Read port is shared: histogram updates never overlap DONE readout.
  assign raddr   = (state_q == S_DONE) ? bus.rd_addr : acc_addr;
  assign rdata_d = mem[raddr];

  // The word written last cycle is not yet visible in rdata_q; forward it.
  assign base  = (wb_valid_q && (wb_addr_q == p_addr_q)) ? wb_data_q : rdata_q;
  assign inc   = (base == {HIST_W{1'b1}}) ? base : base + HIST_W'(1);
  assign we    = clr_en || p_valid_q;
  assign waddr = clr_en ? clr_addr_q : p_addr_q;
  assign wdata = clr_en ? '0 : inc;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    run_cnt_d  = run_cnt_q;
    drain_d    = drain_q;
    clr_addr_d = clr_addr_q;
    ovf_d      = ovf_q;
    samp_d     = samp_q;
    case (state_q)
      S_CLEAR: begin
        if (clr_en) begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
          if (clr_addr_q == ADDR_LAST) state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (start) begin
          state_d   = S_WARMUP;
          run_cnt_d = '0;
          ovf_d     = '0;
          samp_d    = '0;
        end
      end
      S_WARMUP: begin
        run_cnt_d = run_cnt_q + CNT_W'(1);
        if (run_cnt_q == WARM_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q + CNT_W'(1);
        if (run_cnt_q == TOTAL_LAST) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_W'(CHAN_LAT + 1);
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      S_DONE: begin
        if (start) state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase

    if (level_valid)
      lfsr_d = lfsr_q[0] ? ({1'b0, lfsr_q[31:1]} ^ LFSR_MASK) : {1'b0, lfsr_q[31:1]};

    if (acc) begin
      if (samp_q != {CNT_W{1'b1}})       samp_d = samp_q + CNT_W'(1);
      if (ovf && ovf_q != {HIST_W{1'b1}}) ovf_d = ovf_q + HIST_W'(1);
    end

    busy_d = (state_d == S_CLEAR) || (state_d == S_WARMUP) ||
             (state_d == S_RUN)   || (state_d == S_DRAIN);

    dly_d    = dly_q;
    dly_d[0] = {(state_q == S_RUN), bus.level_out};
    for (int i = 1; i < CHAN_LAT; i++) dly_d[i] = dly_q[i-1];

    p_valid_d  = acc;
    p_addr_d   = acc_addr;
    wb_valid_d = p_valid_q;
    wb_addr_d  = p_addr_q;
    wb_data_d  = inc;
    rd_valid_d = bus.rd_en && (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_CLEAR;
      lfsr_q     <= LFSR_SEED;
      run_cnt_q  <= '0;
      drain_q    <= '0;
      clr_addr_q <= '0;
      busy_q     <= 1'b0;
      dly_q      <= '0;
      p_valid_q  <= 1'b0;
      p_addr_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= '0;
      samp_q     <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      run_cnt_q  <= run_cnt_d;
      drain_q    <= drain_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
      dly_q      <= dly_d;
      p_valid_q  <= p_valid_d;
      p_addr_q   <= p_addr_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      samp_q     <= samp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign bus.level_valid = level_valid;
  assign bus.level_out   = level_valid ? lfsr_q[LEVEL_BITS-1:0] : '0;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_valid_q ? rdata_q : '0;
  assign busy            = busy_q;
  assign done            = (state_q == S_DONE);
  assign ovf_cnt         = ovf_q;
  assign sample_cnt      = samp_q;

`ifdef CHAN_MINMAX_EN
  logic [VOLT_W-1:0] min_q, min_d, max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (run_start) begin
      min_d = '1;
      max_d = '0;
    end else if (acc) begin
      if (bus.volt_in < min_q) min_d = bus.volt_in;
      if (bus.volt_in > max_q) max_d = bus.volt_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_volt = min_q;
  assign max_volt = max_q;
`else
  assign min_volt = '0;
  assign max_volt = '0;
`endif
endmodule

// File: tb/tb_chan_stim_hist.sv
module tb_chan_stim_hist;
  localparam int LB = 1, VW = 16, BB = 2, BS = 4, HW = 20, CW = 20;
  localparam int WU = 4, TOT = 20, LAT = 1, NB = 8;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic [HW-1:0] ovf_cnt;
  logic [CW-1:0] sample_cnt;
  logic [VW-1:0] min_volt, max_volt;

  chan_stim_hist_if #(.LEVEL_BITS(LB), .VOLT_W(VW), .BIN_BITS(BB), .HIST_W(HW)) bus_if ();

  chan_stim_hist #(
    .LEVEL_BITS(LB), .VOLT_W(VW), .BIN_BITS(BB), .BIN_SHIFT(BS), .HIST_W(HW),
    .CNT_W(CW), .WARMUP_CYCLES(WU), .TOTAL_CYCLES(TOT), .CHAN_LAT(LAT), .LFSR_SEED(SEED)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus_if),
    .busy(busy), .done(done), .ovf_cnt(ovf_cnt), .sample_cnt(sample_cnt),
    .min_volt(min_volt), .max_volt(max_volt)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_lfsr;
  int m_lvl [TOT];
  int exp_hist [NB];
  int exp_samples, exp_ovf, exp_min, exp_max;
  int rd_seen [NB];
  int mon_idx = -1;
  logic [3:0] seen_lv;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic int volt_of(input int pat, input int j);
    case (pat)
      0: return 'h15;
      1: return 'hFF;
      2: return 'h20;
      3: return (5 + 2 * j > 40) ? 40 : 5 + 2 * j;
      4: return 'h35;
      5: return j * 7;
      default: return 0;
    endcase
  endfunction

  function automatic bit valid_of(input int pat, input int j);
    if (pat == 4) return (j % 3) != 0;
    if (pat == 6) return 1'b0;
    return 1'b1;
  endfunction

  // Level i is driven in stimulus cycle i; its voltage returns in cycle i+LAT.
  function automatic void build_model(input int pat);
    int b, v;
    for (int i = 0; i < TOT; i++) begin
      m_lvl[i] = int'(m_lfsr[0]);
      m_lfsr   = lfsr_step(m_lfsr);
    end
    for (int a = 0; a < NB; a++) exp_hist[a] = 0;
    exp_samples = 0; exp_ovf = 0; exp_min = 'hFFFF; exp_max = 0;
    for (int i = WU; i < TOT; i++) begin
      if (valid_of(pat, i + LAT)) begin
        v = volt_of(pat, i + LAT);
        b = v >> BS;
        if (b > 3) begin
          b = 3;
          exp_ovf++;
        end
        exp_hist[m_lvl[i] * 4 + b]++;
        exp_samples++;
        if (v < exp_min) exp_min = v;
        if (v > exp_max) exp_max = v;
      end
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  bit prev_done = 1'b0;
  bit prev_rd_en = 1'b0;

  always @(negedge clk) begin
    if (mon_idx >= 0 && mon_idx < TOT) begin
      check("level_valid_run", longint'(bus_if.level_valid), 1);
      check("level_out_run", longint'(bus_if.level_out), m_lvl[mon_idx]);
      if (mon_idx < 4) seen_lv[mon_idx] = bus_if.level_out;
    end else begin
      check("level_valid_off", longint'(bus_if.level_valid), 0);
      check("level_out_off", longint'(bus_if.level_out), 0);
    end
    check("rd_valid_gate", longint'(bus_if.rd_valid), longint'(prev_done && prev_rd_en));
    prev_done  = done;
    prev_rd_en = bus_if.rd_en;
  end

  // ---------------- driver ----------------
  task automatic read_hist();
    for (int a = 0; a < NB; a++) begin
      @(posedge clk); #1;
      bus_if.rd_en = 1'b1;
      bus_if.rd_addr = 3'(a);
      @(posedge clk); #1;
      bus_if.rd_en = 1'b0;
      @(negedge clk);
      rd_seen[a] = int'(bus_if.rd_data);
      check($sformatf("hist[%0d]", a), longint'(bus_if.rd_data), exp_hist[a]);
    end
  endtask

  task automatic to_idle();
    int n;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("back_to_idle", longint'(busy || done), 0);
  endtask

  task automatic run_pat(input int pat);
    int n;
    build_model(pat);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int j = 0; j < TOT + LAT + 6; j++) begin
      mon_idx = j;
      bus_if.volt_valid = valid_of(pat, j);
      bus_if.volt_in = 16'(volt_of(pat, j));
      start = (pat == 5 && j == 8);
      @(posedge clk); #1;
    end
    mon_idx = -1;
    start = 1'b0;
    bus_if.volt_valid = 1'b0;
    n = 0;
    while (!done && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_reached", longint'(done), 1);
    check("busy_in_done", longint'(busy), 0);
    check("sample_cnt", longint'(sample_cnt), exp_samples);
    check("ovf_cnt", longint'(ovf_cnt), exp_ovf);
`ifdef CHAN_MINMAX_EN
    check("min_volt", longint'(min_volt), exp_min);
    check("max_volt", longint'(max_volt), exp_max);
`else
    check("min_volt_off", longint'(min_volt), 0);
    check("max_volt_off", longint'(max_volt), 0);
`endif
    read_hist();
  endtask

  initial begin
    int n;
    bus_if.volt_in = '0;
    bus_if.volt_valid = 1'b0;
    bus_if.rd_en = 1'b0;
    bus_if.rd_addr = '0;
    m_lfsr = SEED;
    #2;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_sample_cnt", longint'(sample_cnt), 0);
    check("rst_ovf_cnt", longint'(ovf_cnt), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("clear_busy_cycles", n, 8);
    check("idle_done", longint'(done), 0);
    // Readout outside DONE must be ignored.
    @(posedge clk); #1 bus_if.rd_en = 1'b1; bus_if.rd_addr = 3'd5;
    @(posedge clk); #1 bus_if.rd_en = 1'b0;
    @(negedge clk);
    check("rd_valid_idle", longint'(bus_if.rd_valid), 0);

    run_pat(6);
    check("seed_levels_first", longint'(seen_lv), 4'b1000);
    to_idle();

    run_pat(0);
    check("p0_samples_lit", longint'(sample_cnt), 16);
    check("p0_ovf_lit", longint'(ovf_cnt), 0);
    check("p0_bin1_sum", rd_seen[1] + rd_seen[5], 16);
    to_idle();

    run_pat(1);
    check("p1_ovf_lit", longint'(ovf_cnt), 16);
    check("p1_bin3_sum", rd_seen[3] + rd_seen[7], 16);
    to_idle();

    run_pat(2);
    check("p2_bin2_sum", rd_seen[2] + rd_seen[6], 16);
    to_idle();

    run_pat(4);
    to_idle();
    run_pat(5);
    to_idle();

    run_pat(3);
`ifdef CHAN_MINMAX_EN
    check("p3_min_lit", longint'(min_volt), 15);
    check("p3_max_lit", longint'(max_volt), 40);
`else
    check("p3_min_off_lit", longint'(min_volt), 0);
    check("p3_max_off_lit", longint'(max_volt), 0);
`endif
    to_idle();

    // Abort a run with reset at run cycle 10.
    build_model(0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int j = 0; j < 10; j++) begin
      mon_idx = j;
      bus_if.volt_valid = 1'b1;
      bus_if.volt_in = 16'h0015;
      @(posedge clk); #1;
    end
    mon_idx = -1;
    reset = 1'b0;
    m_lfsr = SEED;
    #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    check("abort_samples", longint'(sample_cnt), 0);
    check("abort_ovf", longint'(ovf_cnt), 0);
    check("abort_rd_valid", longint'(bus_if.rd_valid), 0);
    check("abort_rd_data", longint'(bus_if.rd_data), 0);
    check("abort_min", longint'(min_volt), 0);
    check("abort_max", longint'(max_volt), 0);
    bus_if.volt_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("abort_clear_cycles", n, 8);
    run_pat(0);
    check("seed_levels_rerun", longint'(seen_lv), 4'b1000);
    check("rerun_samples_lit", longint'(sample_cnt), 16);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
